// File: rtl/lidar_peak_framer.sv
// lidar_peak_framer: finds the brightest pixel of each CCD line and writes a
// short packet {hdr, peak index, peak value, checksum} into a serial FIFO.
// Optional macro PEAK_WIDTH_EN adds an above-threshold pixel count
// (two extra bytes, 8-byte packet).
// out_wrreq is gated combinationally by wr_full so that a byte is written
// only in a cycle where the FIFO is not full; all other outputs are registered.
module lidar_peak_framer #(
   parameter int unsigned FRAME_LEN = 1024,
   parameter logic [7:0]  THRESH    = 8'd20,
   parameter logic [7:0]  HDR0      = 8'hAA,
   parameter logic [7:0]  HDR1      = 8'h55
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       pix_valid,
   input  logic [7:0] pix_data,
   input  logic       wr_full,
   output logic       out_frameclk,
   output logic       out_wrreq,
   output logic [7:0] out_data,
   output logic [7:0] drop_cnt
);

   localparam int unsigned CW = 11;
   localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_LEN - 1);
`ifdef PEAK_WIDTH_EN
   localparam int unsigned NBYTES = 8;
`else
   localparam int unsigned NBYTES = 6;
`endif
   localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, ACQ, MARK, SEND} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   pix_cnt_q, pix_cnt_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [7:0]      peak_q, peak_d;
   logic            hit_q, hit_d;
   logic [2:0]      byte_q, byte_d;
   logic [7:0]      data_q, data_d;
   logic            fclk_q, fclk_d;
   logic [7:0]      drop_q, drop_d;
   logic            drop_inc;
`ifdef PEAK_WIDTH_EN
   logic [CW-1:0]   wid_q, wid_d;
`endif

   logic [CW-1:0]   idx_rep;
   logic [7:0]      csum;
   logic [7:0]      pkt [8];
   logic [2:0]      byte_nx;

   // Packet assembly from the frame accumulators; "no hit" reports index 0x7FF.
   always_comb begin
      idx_rep = hit_q ? idx_q : 11'h7FF;
      pkt[0]  = HDR0;
      pkt[1]  = HDR1;
      pkt[2]  = {5'b0, idx_rep[10:8]};
      pkt[3]  = idx_rep[7:0];
      pkt[4]  = peak_q;
`ifdef PEAK_WIDTH_EN
      pkt[5]  = {5'b0, wid_q[10:8]};
      pkt[6]  = wid_q[7:0];
      csum    = pkt[2] + pkt[3] + pkt[4] + pkt[5] + pkt[6];
      pkt[7]  = csum;
`else
      csum    = pkt[2] + pkt[3] + pkt[4];
      pkt[5]  = csum;
      pkt[6]  = 8'h00;
      pkt[7]  = 8'h00;
`endif
   end

   // Next-state and accumulator/output register updates.
   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      idx_d     = idx_q;
      peak_d    = peak_q;
      hit_d     = hit_q;
      byte_d    = byte_q;
      data_d    = data_q;
      fclk_d    = 1'b0;
      drop_d    = drop_q;
      drop_inc  = 1'b0;
      byte_nx   = 3'(byte_q + 3'd1);
`ifdef PEAK_WIDTH_EN
      wid_d     = wid_q;
`endif
      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d   = ACQ;
               pix_cnt_d = '0;
               idx_d     = '0;
               peak_d    = '0;
               hit_d     = 1'b0;
`ifdef PEAK_WIDTH_EN
               wid_d     = '0;
`endif
            end
         end
         ACQ: begin
            if (frame_start) begin
               // Partial line is discarded; restart on the new line.
               drop_inc  = 1'b1;
               pix_cnt_d = '0;
               idx_d     = '0;
               peak_d    = '0;
               hit_d     = 1'b0;
`ifdef PEAK_WIDTH_EN
               wid_d     = '0;
`endif
            end else if (pix_valid) begin
               pix_cnt_d = CW'(pix_cnt_q + CW'(1));
               if (pix_data >= THRESH && (!hit_q || pix_data > peak_q)) begin
                  peak_d = pix_data;
                  idx_d  = pix_cnt_q;
                  hit_d  = 1'b1;
               end
`ifdef PEAK_WIDTH_EN
               if (pix_data >= THRESH && wid_q != 11'h7FF) begin
                  wid_d = CW'(wid_q + CW'(1));
               end
`endif
               if (pix_cnt_q == LAST_PIX) begin
                  state_d = MARK;
                  fclk_d  = 1'b1;
               end
            end
         end
         MARK: begin
            drop_inc = frame_start;
            state_d  = SEND;
            byte_d   = 3'd0;
            data_d   = pkt[0];
         end
         SEND: begin
            drop_inc = frame_start;
            if (!wr_full) begin
               if (byte_q == LAST_BYTE) begin
                  state_d = IDLE;
                  byte_d  = 3'd0;
                  data_d  = 8'h00;
               end else begin
                  byte_d = byte_nx;
                  data_d = pkt[byte_nx];
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (drop_inc && drop_q != 8'hFF) begin
         drop_d = 8'(drop_q + 8'd1);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pix_cnt_q <= '0;
         idx_q     <= '0;
         peak_q    <= '0;
         hit_q     <= 1'b0;
         byte_q    <= 3'd0;
         data_q    <= 8'h00;
         fclk_q    <= 1'b0;
         drop_q    <= 8'h00;
`ifdef PEAK_WIDTH_EN
         wid_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         idx_q     <= idx_d;
         peak_q    <= peak_d;
         hit_q     <= hit_d;
         byte_q    <= byte_d;
         data_q    <= data_d;
         fclk_q    <= fclk_d;
         drop_q    <= drop_d;
`ifdef PEAK_WIDTH_EN
         wid_q     <= wid_d;
`endif
      end
   end

   assign out_frameclk = fclk_q;
   assign out_wrreq    = (state_q == SEND) && !wr_full;
   assign out_data     = data_q;
   assign drop_cnt     = drop_q;

endmodule

// File: doc/lidar_peak_framer.md
LIDAR_PEAK_FRAMER -- requirements
Module: lidar_peak_framer

Interface
REQ-001 Parameter FRAME_LEN, default 1024: valid pixels per CCD line (2..2047).
REQ-002 Parameter THRESH, default 8'd20: minimum pixel value accepted as a peak candidate.
REQ-003 Parameter HDR0/HDR1, default 8'hAA/8'h55: packet header bytes.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 frame_start  in  1  one-cycle pulse marking the start of a CCD line (upstream ADC control).
REQ-007 pix_valid  in  1  pixel strobe, one pixel per high cycle.
REQ-008 pix_data  in  8  ADC pixel value, qualified by pix_valid.
REQ-009 wr_full  in  1  downstream serial FIFO full flag.
REQ-010 out_frameclk  out  1  one-cycle pulse preceding each packet.
REQ-011 out_wrreq  out  1  FIFO write strobe, one byte per high cycle.
REQ-012 out_data  out  8  FIFO write byte, valid when out_wrreq=1.
REQ-013 drop_cnt  out  8  saturating count of discarded or truncated frames.

Function
REQ-014 The FSM SHALL have states IDLE, ACQ, MARK, SEND.
REQ-015 IDLE: frame_start=1 -> ACQ next cycle; pixel counter, peak value and peak index clear to 0; pix_valid ignored.
REQ-016 ACQ: each pix_valid increments the 11-bit pixel counter; the pixel index is the counter value before the increment.
REQ-017 ACQ: pix_data >= THRESH and pix_data > stored peak -> store value and index; ties keep the first occurrence.
REQ-018 If no pixel reaches THRESH: peak=0x00 and index=0x7FF.
REQ-019 On the FRAME_LEN-th valid pixel -> MARK next cycle.
REQ-020 frame_start while in ACQ: drop the partial frame, increment drop_cnt, restart ACQ with cleared accumulators.
REQ-021 MARK: drive out_frameclk=1 for exactly one cycle -> SEND.
REQ-022 SEND: emit 6 bytes in this order:
- HDR0
- HDR1
- {5'b0, idx[10:8]}
- idx[7:0]
- peak
- checksum = (byte2 + byte3 + byte4) mod 256
REQ-023 One byte SHALL be written per cycle, only in cycles where wr_full=0; a byte SHALL NOT be skipped or repeated across stalls.
REQ-024 After the 6th byte -> IDLE.
REQ-025 frame_start during MARK or SEND: ignore the frame, increment drop_cnt, complete the current packet.
REQ-026 drop_cnt SHALL saturate at 255.
REQ-027 Minimum latency, last pixel to first byte: 2 cycles (MARK then SEND).

Reset
REQ-028 While rst_n=0:
- FSM in IDLE
- out_frameclk=0, out_wrreq=0, out_data=0x00, drop_cnt=0
- all accumulators cleared
REQ-029 Reset asserted mid-packet SHALL abort it; no further bytes after release until a new frame_start.

Configuration
REQ-030 Macro PEAK_WIDTH_EN defined: the block additionally counts pixels >= THRESH in the frame (11-bit, saturating).
- Two bytes {5'b0, w[10:8]} and w[7:0] are inserted before the checksum.
- The checksum also covers these two bytes.
- Packet length is 8 bytes.
REQ-031 Macro PEAK_WIDTH_EN undefined: 6-byte packet per REQ-022; no width counter logic is present.

Verification
REQ-032 FRAME_LEN=8, THRESH=20, pixels 5,30,90,90,40,10,0,0 -> packet AA 55 00 02 5A 5C (PEAK_WIDTH_EN off).
REQ-033 All pixels 10 -> packet AA 55 07 FF 00 06; out_frameclk pulse one cycle before the AA write.
REQ-034 wr_full high for 3 cycles after the 2nd byte -> bytes 3-6 resume unchanged; 6 out_wrreq pulses total.
REQ-035 frame_start after 4 pixels of a frame -> drop_cnt=1; the following full frame produces a correct packet.
REQ-036 rst_n low during the 4th byte -> outputs 0 immediately; no bytes after release until a new frame_start.
REQ-037 PEAK_WIDTH_EN on, stimulus of REQ-032 -> AA 55 00 02 5A 00 04 60.
